axi_lite_sram_bridge: RTL and testbench

AXI_LITE_SRAM_BRIDGE -- requirements
Module: axi_lite_sram_bridge

---
 rtl/axi_lite_sram_bridge_if.sv | 46 ++++
 rtl/axi_lite_sram_bridge.sv | 126 ++++++++++++
 tb/tb_axi_lite_sram_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sram_bridge_if
// Description : AXI-lite slave-side bus bundle for the SRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_sram_bridge_if;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_awaddr;
    logic [2:0]  s_awprot;
    logic        s_wvalid;
    logic        s_wready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid;
    logic        s_bready;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arprot;
    logic        s_rvalid;
    logic        s_rready;
    logic [31:0] s_rdata;

    modport slave (
        input  s_awvalid, s_awaddr, s_awprot,
        input  s_wvalid, s_wdata, s_wstrb,
        input  s_bready,
        input  s_arvalid, s_araddr, s_arprot,
        input  s_rready,
        output s_awready, s_wready, s_bvalid,
        output s_arready, s_rvalid, s_rdata
    );

    modport master (
        output s_awvalid, s_awaddr, s_awprot,
        output s_wvalid, s_wdata, s_wstrb,
        output s_bready,
        output s_arvalid, s_araddr, s_arprot,
        output s_rready,
        input  s_awready, s_wready, s_bvalid,
        input  s_arready, s_rvalid, s_rdata
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sram_bridge
// Description : AXI-lite slave to single-port synchronous SRAM bridge with
//               alternating read/write arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_sram_bridge #(
    parameter int          ADDR_W      = 12,
    parameter logic [31:0] RDATA_RESET = 32'h0000_0000
) (
    input  wire logic                clk,
    input  wire logic                resetn,
    axi_lite_sram_bridge_if.slave    s_axi,
    output logic                     mem_en,
    output logic [3:0]               mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  wire logic [31:0]         mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_RESP = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant_write;
    logic [31:0] r_rdata;
    logic        w_grant_wr;
    logic        w_grant_rd;
    logic        w_wr_req;

    // Protection bits, byte offset and aliased upper address bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{s_axi.s_awprot, s_axi.s_arprot,
                             s_axi.s_awaddr[31:ADDR_W+2], s_axi.s_awaddr[1:0],
                             s_axi.s_araddr[31:ADDR_W+2], s_axi.s_araddr[1:0]};

    assign w_wr_req = s_axi.s_awvalid && s_axi.s_wvalid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_wr      = 1'b0;
        w_grant_rd      = 1'b0;
        s_axi.s_awready = 1'b0;
        s_axi.s_wready  = 1'b0;
        s_axi.s_arready = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 4'b0000;
        mem_addr        = '0;
        mem_wdata       = '0;
        case (r_state)
            IDLE: begin
                // resetn gates the grant so no strobe or ready escapes while reset is held.
                if (resetn) begin
                    if (w_wr_req && (!s_axi.s_arvalid || !r_last_grant_write)) begin
                        w_grant_wr      = 1'b1;
                        s_axi.s_awready = 1'b1;
                        s_axi.s_wready  = 1'b1;
                        mem_en          = |s_axi.s_wstrb;
                        mem_we          = s_axi.s_wstrb;
                        mem_addr        = s_axi.s_awaddr[ADDR_W+1:2];
                        mem_wdata       = s_axi.s_wdata;
                        w_state_nxt     = WR_RESP;
                    end else if (s_axi.s_arvalid) begin
                        w_grant_rd      = 1'b1;
                        s_axi.s_arready = 1'b1;
                        mem_en          = 1'b1;
                        mem_addr        = s_axi.s_araddr[ADDR_W+1:2];
                        w_state_nxt     = RD_WAIT;
                    end
                end
            end
            WR_RESP: begin
                if (s_axi.s_bready) begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                w_state_nxt = RD_RESP;
            end
            RD_RESP: begin
                if (s_axi.s_rready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant_write <= 1'b0;
            r_rdata            <= RDATA_RESET;
        end else begin
            if (w_grant_wr) begin
                r_last_grant_write <= 1'b1;
            end else if (w_grant_rd) begin
                r_last_grant_write <= 1'b0;
            end
            if (r_state == RD_WAIT) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign s_axi.s_bvalid = (r_state == WR_RESP);
    assign s_axi.s_rvalid = (r_state == RD_RESP);
    assign s_axi.s_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_sram_bridge
// Description : Directed self-checking bench for axi_lite_sram_bridge with an
//               SRAM model, a reference memory and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_bridge;

    localparam int          C_AW    = 12;
    localparam logic [31:0] C_RDRST = 32'hDEAD_BEEF;

    logic              clk;
    logic              resetn;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [C_AW-1:0]   mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sram    [0:(1<<C_AW)-1];
    logic [31:0] ref_mem [0:(1<<C_AW)-1];
    logic [31:0] sb [$];

    axi_lite_sram_bridge_if bus ();

    axi_lite_sram_bridge #(
        .ADDR_W      (C_AW),
        .RDATA_RESET (C_RDRST)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_axi     (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= sram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_valids();
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.s_awvalid = 1'b1;
        bus.s_awaddr  = a;
        bus.s_wvalid  = 1'b1;
        bus.s_wdata   = d;
        bus.s_wstrb   = s;
    endtask

    task automatic drive_rd(input logic [31:0] a);
        bus.s_arvalid = 1'b1;
        bus.s_araddr  = a;
    endtask

    task automatic expect_wr_grant(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [C_AW-1:0] idx;
        idx = a[C_AW+1:2];
        check("wr_awready", bus.s_awready, 1);
        check("wr_wready", bus.s_wready, 1);
        check("wr_arready", bus.s_arready, 0);
        check("wr_mem_en", mem_en, (s != 4'b0000));
        check("wr_mem_we", mem_we, s);
        check("wr_mem_addr", mem_addr, idx);
        if (s != 4'b0000) check("wr_mem_wdata", mem_wdata, d);
        ref_mem[idx] = merge(ref_mem[idx], d, s);
    endtask

    task automatic expect_rd_grant(input logic [31:0] a);
        logic [C_AW-1:0] idx;
        idx = a[C_AW+1:2];
        check("rd_arready", bus.s_arready, 1);
        check("rd_awready", bus.s_awready, 0);
        check("rd_wready", bus.s_wready, 0);
        check("rd_mem_en", mem_en, 1);
        check("rd_mem_we", mem_we, 0);
        check("rd_mem_addr", mem_addr, idx);
        sb.push_back(ref_mem[idx]);
    endtask

    // Entered at the grant-cycle negedge; returns just after the B handshake edge.
    task automatic finish_write(input int hold, input bit bp);
        int lat;
        @(posedge clk); #1; clear_valids();
        @(negedge clk);
        lat = 1;
        while (bus.s_bvalid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("wr_latency", lat, 1);
        if (bp) begin
            drive_wr(32'h0000_0F00, 32'h0BAD_0BAD, 4'hF);
            drive_rd(32'h0000_0F00);
        end
        for (int i = 0; i < hold; i++) begin
            #1;
            check("bp_bvalid", bus.s_bvalid, 1);
            check("bp_awready", bus.s_awready, 0);
            check("bp_wready", bus.s_wready, 0);
            check("bp_arready", bus.s_arready, 0);
            check("bp_mem_en", mem_en, 0);
            @(negedge clk);
        end
        clear_valids();
        bus.s_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_bready = 1'b0;
    endtask

    task automatic finish_read(input int hold);
        int lat;
        logic [31:0] exp;
        @(posedge clk); #1; clear_valids();
        @(negedge clk);
        lat = 1;
        while (bus.s_rvalid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", lat, 2);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        check("rd_data", bus.s_rdata, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_rvalid", bus.s_rvalid, 1);
            check("bp_rdata", bus.s_rdata, exp);
            check("bp_arready", bus.s_arready, 0);
        end
        bus.s_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, input bit bp);
        drive_wr(a, d, s);
        @(negedge clk);
        expect_wr_grant(a, d, s);
        finish_write(hold, bp);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        drive_rd(a);
        @(negedge clk);
        expect_rd_grant(a);
        finish_read(hold);
    endtask

    initial begin
        for (int i = 0; i < (1 << C_AW); i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_rdata    = 32'h0;
        resetn       = 1'b0;
        bus.s_awprot = 3'b000;
        bus.s_arprot = 3'b000;
        bus.s_bready = 1'b0;
        bus.s_rready = 1'b0;
        drive_wr(32'h0000_0008, 32'h1234_5678, 4'hF);
        drive_rd(32'h0000_0008);

        // Reset state with every request asserted.
        repeat (2) @(negedge clk);
        check("rst_awready", bus.s_awready, 0);
        check("rst_wready", bus.s_wready, 0);
        check("rst_arready", bus.s_arready, 0);
        check("rst_bvalid", bus.s_bvalid, 0);
        check("rst_rvalid", bus.s_rvalid, 0);
        check("rst_rdata", bus.s_rdata, C_RDRST);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_addr_known", $isunknown(mem_addr), 0);
        check("rst_wdata_known", $isunknown(mem_wdata), 0);
        clear_valids();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Contention alternation: write, read, write, read.
        drive_wr(32'h0000_0020, 32'h1111_2222, 4'hF);
        drive_rd(32'h0000_0020);
        @(negedge clk);
        expect_wr_grant(32'h0000_0020, 32'h1111_2222, 4'hF);
        finish_write(0, 0);
        drive_wr(32'h0000_0024, 32'h3333_4444, 4'hF);
        drive_rd(32'h0000_0020);
        @(negedge clk);
        expect_rd_grant(32'h0000_0020);
        finish_read(0);
        drive_wr(32'h0000_0024, 32'h3333_4444, 4'hF);
        drive_rd(32'h0000_0024);
        @(negedge clk);
        expect_wr_grant(32'h0000_0024, 32'h3333_4444, 4'hF);
        finish_write(0, 0);
        drive_wr(32'h0000_0028, 32'h5555_6666, 4'hF);
        drive_rd(32'h0000_0024);
        @(negedge clk);
        expect_rd_grant(32'h0000_0024);
        finish_read(0);

        // Write then read, plus an aliased read of the same word.
        do_write(32'h0000_0010, 32'hCAFE_F00D, 4'hF, 0, 0);
        do_read(32'h0000_0010, 0);
        do_read(32'h0000_4013, 0);

        // Partial and empty strobes.
        do_write(32'h0000_0030, 32'h1122_3344, 4'hF, 0, 0);
        do_write(32'h0000_0030, 32'hAABB_CCDD, 4'h5, 0, 0);
        do_read(32'h0000_0030, 0);
        do_write(32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 0, 0);
        do_read(32'h0000_0030, 0);

        // Response backpressure on both channels.
        do_write(32'h0000_0040, 32'h5A5A_A5A5, 4'hF, 5, 1);
        do_read(32'h0000_0040, 5);

        // AW waits three cycles for W.
        bus.s_awvalid = 1'b1;
        bus.s_awaddr  = 32'h0000_0050;
        bus.s_wdata   = 32'h0F0F_F0F0;
        bus.s_wstrb   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_only_awready", bus.s_awready, 0);
            check("aw_only_wready", bus.s_wready, 0);
            check("aw_only_mem_en", mem_en, 0);
            @(posedge clk); #1;
        end
        bus.s_wvalid = 1'b1;
        @(negedge clk);
        expect_wr_grant(32'h0000_0050, 32'h0F0F_F0F0, 4'hF);
        finish_write(0, 0);
        do_read(32'h0000_0050, 0);

        // Reset while a write is offered: nothing may reach the SRAM.
        drive_wr(32'h0000_0060, 32'h7777_8888, 4'hF);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("rstwr_mem_en", mem_en, 0);
        check("rstwr_awready", bus.s_awready, 0);
        @(posedge clk); #1;
        clear_valids();
        resetn = 1'b1;
        @(posedge clk); #1;
        do_read(32'h0000_0060, 0);

        // Reset during RD_WAIT drops the response.
        do_write(32'h0000_0004, 32'h0BAD_CAFE, 4'hF, 0, 0);
        drive_rd(32'h0000_0004);
        @(negedge clk);
        expect_rd_grant(32'h0000_0004);
        sb.delete();
        @(posedge clk); #1;
        clear_valids();
        #1 resetn = 1'b0;
        #1;
        check("rstrd_rvalid", bus.s_rvalid, 0);
        check("rstrd_rdata", bus.s_rdata, C_RDRST);
        @(negedge clk);
        check("rstrd_rvalid_hold", bus.s_rvalid, 0);
        @(posedge clk); #1;
        check("rstrd_rdata_hold", bus.s_rdata, C_RDRST);
        resetn = 1'b1;
        @(posedge clk); #1;
        do_read(32'h0000_0004, 0);

        // After reset the write again wins contention.
        drive_wr(32'h0000_0070, 32'h9999_AAAA, 4'hF);
        drive_rd(32'h0000_0004);
        @(negedge clk);
        expect_wr_grant(32'h0000_0070, 32'h9999_AAAA, 4'hF);
        finish_write(0, 0);
        do_read(32'h0000_0070, 0);

        check("sb_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
